// File: rtl/aging_report_rx.sv
// aging_report_rx: receive side of the aging sensor's UART report link.
// Deserializes 8N1 frames (8E1 when AGING_RX_PARITY_EN is defined),
// rejects malformed frames and tracks the last, peak and alarm aging levels
// plus a saturating count of accepted frames.
//
// Output protocol: rx_valid and frame_err are one-cycle strobes with no
// ready/backpressure. rx_valid qualifies rx_data/aging_level in the cycle it is
// high. Both strobes appear one cycle after the stop-bit sample and never
// together. The consumer must take a strobe in the cycle it is seen.
//
// fsm_state exposes the receiver state encoding (IDLE=0, START=1, DATA=2,
// STOP=3, WAIT_HIGH=4, PARITY=5) for debug and checkers.
module aging_report_rx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned COUNT_WINDOW = 4,
    parameter logic [COUNT_WINDOW-1:0] ALARM_THRESH = 4'd8
) (
    input  logic                    clk,
    input  logic                    reset_Q1,
    input  logic                    rxd,
    input  logic                    clr_peak,
    output logic [7:0]              rx_data,
    output logic                    rx_valid,
    output logic                    frame_err,
    output logic [COUNT_WINDOW-1:0] aging_level,
    output logic [COUNT_WINDOW-1:0] aging_peak,
    output logic                    aging_alarm,
    output logic [15:0]             frame_cnt,
    output logic [2:0]              fsm_state
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] FULL_LOAD = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
`ifdef AGING_RX_PARITY_EN
        ,
        ST_PARITY    = 3'd5
`endif
    } state_t;

    state_t                  state;
    logic                    rxd_m;
    logic                    rxd_s;
    logic [TW-1:0]           timer;
    logic [2:0]              bit_idx;
    logic [7:0]              shreg;
    logic [COUNT_WINDOW-1:0] level;
    logic                    upper_zero;
    logic                    parity_ok;
    logic                    stop_sample;
    logic                    accept;
    logic [COUNT_WINDOW-1:0] peak_base;
    logic                    alarm_base;

`ifdef AGING_RX_PARITY_EN
    logic                    parity_bit;
`endif

    assign fsm_state = state;

    // Two-flop synchronizer; idles high so reset does not look like a start bit.
    always_ff @(posedge clk or posedge reset_Q1) begin
        if (reset_Q1) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    // Frame qualification and the peak/alarm baseline after an optional clear.
    always_comb begin
        level       = shreg[COUNT_WINDOW-1:0];
        upper_zero  = ((shreg >> COUNT_WINDOW) == 8'd0);
`ifdef AGING_RX_PARITY_EN
        parity_ok   = ~(^{shreg, parity_bit});
`else
        parity_ok   = 1'b1;
`endif
        stop_sample = (state == ST_STOP) && (timer == '0);
        accept      = stop_sample && rxd_s && upper_zero && parity_ok;
        peak_base   = clr_peak ? '0 : aging_peak;
        alarm_base  = clr_peak ? 1'b0 : aging_alarm;
    end

    // Receiver FSM: bit timing, shifting and the accept/reject strobes.
    always_ff @(posedge clk or posedge reset_Q1) begin
        if (reset_Q1) begin
            state      <= ST_IDLE;
            timer      <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
`ifdef AGING_RX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (timer != '0) begin
                timer <= timer - TW'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (!rxd_s) begin
                        state <= ST_START;
                        timer <= HALF_LOAD;
                    end
                end
                ST_START: begin
                    if (timer == '0) begin
                        if (!rxd_s) begin
                            state   <= ST_DATA;
                            timer   <= FULL_LOAD;
                            bit_idx <= '0;
                        end else begin
                            // Start bit vanished by mid-bit: treat as a glitch.
                            state <= ST_IDLE;
                            timer <= FULL_LOAD;
                        end
                    end
                end
                ST_DATA: begin
                    if (timer == '0) begin
                        shreg   <= {rxd_s, shreg[7:1]};
                        timer   <= FULL_LOAD;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef AGING_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end
                    end
                end
`ifdef AGING_RX_PARITY_EN
                ST_PARITY: begin
                    if (timer == '0) begin
                        parity_bit <= rxd_s;
                        timer      <= FULL_LOAD;
                        state      <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (stop_sample) begin
                        timer <= FULL_LOAD;
                        if (!rxd_s) begin
                            // Low stop bit: wait out a possible break so it
                            // yields exactly one error.
                            frame_err <= 1'b1;
                            state     <= ST_WAIT_HIGH;
                        end else if (accept) begin
                            rx_valid <= 1'b1;
                            state    <= ST_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= ST_IDLE;
                        end
                    end
                end
                ST_WAIT_HIGH: begin
                    if (rxd_s) begin
                        state <= ST_IDLE;
                        timer <= FULL_LOAD;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    timer <= FULL_LOAD;
                end
            endcase
        end
    end

    // Result registers: updated only by accepted frames; clear applies before update.
    always_ff @(posedge clk or posedge reset_Q1) begin
        if (reset_Q1) begin
            rx_data     <= '0;
            aging_level <= '0;
            aging_peak  <= '0;
            aging_alarm <= 1'b0;
            frame_cnt   <= '0;
        end else if (accept) begin
            rx_data     <= shreg;
            aging_level <= level;
            aging_peak  <= (level > peak_base) ? level : peak_base;
            aging_alarm <= alarm_base | (level >= ALARM_THRESH);
            if (frame_cnt != 16'hFFFF) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end else if (clr_peak) begin
            aging_peak  <= '0;
            aging_alarm <= 1'b0;
        end
    end

endmodule

// File: tb/tb_aging_report_rx.sv
// Directed bench for aging_report_rx with CLKS_PER_BIT=16, COUNT_WINDOW=4,
// ALARM_THRESH=8. Inputs change and outputs are sampled on the falling edge.
// Frame latency: 2 sync flops + 8-cycle half bit + 8 data bits (+ parity)
// + stop bit, then one cycle for the registered strobe.
module tb_aging_report_rx;

    localparam int CPB = 16;
`ifdef AGING_RX_PARITY_EN
    localparam int FRAME_LAT = 2 + CPB / 2 + 10 * CPB + 1;
`else
    localparam int FRAME_LAT = 2 + CPB / 2 + 9 * CPB + 1;
`endif

    logic        clk = 1'b0;
    logic        reset_Q1 = 1'b1;
    logic        rxd = 1'b1;
    logic        clr_peak = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        frame_err;
    logic [3:0]  aging_level;
    logic [3:0]  aging_peak;
    logic        aging_alarm;
    logic [15:0] frame_cnt;
    logic [2:0]  fsm_state;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int valid_cnt = 0;
    int err_cnt   = 0;
    int both_cnt  = 0;
    int cyc       = 0;
    int start_cyc = 0;
    int last_valid_cyc = 0;
    logic [7:0] exp_q[$];

    aging_report_rx #(
        .CLKS_PER_BIT(CPB),
        .COUNT_WINDOW(4),
        .ALARM_THRESH(4'd8)
    ) dut (
        .clk(clk),
        .reset_Q1(reset_Q1),
        .rxd(rxd),
        .clr_peak(clr_peak),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .frame_err(frame_err),
        .aging_level(aging_level),
        .aging_peak(aging_peak),
        .aging_alarm(aging_alarm),
        .frame_cnt(frame_cnt),
        .fsm_state(fsm_state)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    endtask

    // scoreboard: every rx_valid strobe must match the next expected byte
    always @(negedge clk) begin
        if (rx_valid) begin
            valid_cnt++;
            last_valid_cyc = cyc;
            if (exp_q.size() == 0) begin
                total_cnt++;
                $error("FAIL sb_unexpected_valid: observed rx_data=%0h expected no accept", rx_data);
            end else begin
                chk("sb_rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
            end
        end
        if (frame_err) err_cnt++;
        if (rx_valid && frame_err) both_cnt++;
    end

    // driver tasks (all start and end on a falling edge)
    task automatic send_bit(input logic b);
        rxd = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame_p(input logic [7:0] d, input logic stop_b, input logic par_b);
        start_cyc = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef AGING_RX_PARITY_EN
        send_bit(par_b);
`else
        if (par_b !== ^d) $display("note: parity bit ignored in 8N1 build");
`endif
        send_bit(stop_b);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        send_frame_p(d, stop_b, ^d);
    endtask

    task automatic send_with_clr(input logic [7:0] d);
        fork
            send_frame(d, 1'b1);
            begin
                repeat (FRAME_LAT - 1) @(negedge clk);
                clr_peak = 1'b1;
                @(negedge clk);
                clr_peak = 1'b0;
            end
        join
    endtask

    task automatic clear_mon();
        valid_cnt = 0;
        err_cnt   = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_Q1 = 1'b1;
        rxd      = 1'b1;
        repeat (3) @(negedge clk);
        reset_Q1 = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
        chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("rst_level", {28'd0, aging_level}, 32'd0);
        chk("rst_peak", {28'd0, aging_peak}, 32'd0);
        chk("rst_alarm", {31'd0, aging_alarm}, 32'd0);
        chk("rst_cnt", {16'd0, frame_cnt}, 32'd0);
        chk("rst_state", {29'd0, fsm_state}, 32'd0);
        reset_Q1 = 1'b0;
        repeat (4) @(negedge clk);

        // single frame 0x03
        clear_mon();
        exp_q.push_back(8'h03);
        send_frame(8'h03, 1'b1);
        chk("f03_valid_cnt", valid_cnt, 1);
        chk("f03_err_cnt", err_cnt, 0);
        chk("f03_latency", last_valid_cyc - start_cyc, FRAME_LAT);
        chk("f03_level", {28'd0, aging_level}, 32'd3);
        chk("f03_peak", {28'd0, aging_peak}, 32'd3);
        chk("f03_alarm", {31'd0, aging_alarm}, 32'd0);
        chk("f03_cnt", {16'd0, frame_cnt}, 32'd1);

        // back-to-back 05, 09, 02 from a fresh reset
        do_reset();
        clear_mon();
        exp_q.push_back(8'h05);
        exp_q.push_back(8'h09);
        exp_q.push_back(8'h02);
        send_frame(8'h05, 1'b1);
        send_frame(8'h09, 1'b1);
        send_frame(8'h02, 1'b1);
        chk("b2b_valid_cnt", valid_cnt, 3);
        chk("b2b_latency", last_valid_cyc - start_cyc, FRAME_LAT);
        chk("b2b_rx_data", {24'd0, rx_data}, 32'h02);
        chk("b2b_level", {28'd0, aging_level}, 32'd2);
        chk("b2b_peak", {28'd0, aging_peak}, 32'd9);
        chk("b2b_alarm", {31'd0, aging_alarm}, 32'd1);
        chk("b2b_cnt", {16'd0, frame_cnt}, 32'd3);

        // upper nibble set: rejected, state unchanged
        clear_mon();
        send_frame(8'h31, 1'b1);
        chk("f31_err_cnt", err_cnt, 1);
        chk("f31_valid_cnt", valid_cnt, 0);
        chk("f31_rx_data", {24'd0, rx_data}, 32'h02);
        chk("f31_level", {28'd0, aging_level}, 32'd2);
        chk("f31_peak", {28'd0, aging_peak}, 32'd9);
        chk("f31_cnt", {16'd0, frame_cnt}, 32'd3);

        // bad stop bit followed by a long break
        clear_mon();
        send_frame(8'h04, 1'b0);
        repeat (100) @(negedge clk);
        chk("brk_err_cnt", err_cnt, 1);
        chk("brk_valid_cnt", valid_cnt, 0);
        chk("brk_state_wait", {29'd0, fsm_state}, 32'd4);
        rxd = 1'b1;
        repeat (8) @(negedge clk);
        chk("brk_state_idle", {29'd0, fsm_state}, 32'd0);
        chk("brk_err_once", err_cnt, 1);
        exp_q.push_back(8'h01);
        send_frame(8'h01, 1'b1);
        chk("brk_next_valid", valid_cnt, 1);
        chk("brk_next_level", {28'd0, aging_level}, 32'd1);
        chk("brk_next_peak", {28'd0, aging_peak}, 32'd9);
        chk("brk_next_cnt", {16'd0, frame_cnt}, 32'd4);

        // 5-cycle low glitch
        clear_mon();
        rxd = 1'b0;
        repeat (5) @(negedge clk);
        chk("gl_state_start", {29'd0, fsm_state}, 32'd1);
        rxd = 1'b1;
        repeat (30) @(negedge clk);
        chk("gl_valid_cnt", valid_cnt, 0);
        chk("gl_err_cnt", err_cnt, 0);
        chk("gl_state_idle", {29'd0, fsm_state}, 32'd0);

        // clr_peak coincident with accepts
        clear_mon();
        exp_q.push_back(8'h0A);
        send_with_clr(8'h0A);
        chk("clr0a_valid", valid_cnt, 1);
        chk("clr0a_peak", {28'd0, aging_peak}, 32'd10);
        chk("clr0a_alarm", {31'd0, aging_alarm}, 32'd1);
        exp_q.push_back(8'h02);
        send_with_clr(8'h02);
        chk("clr02_peak", {28'd0, aging_peak}, 32'd2);
        chk("clr02_alarm", {31'd0, aging_alarm}, 32'd0);
        chk("clr02_cnt", {16'd0, frame_cnt}, 32'd6);
        exp_q.push_back(8'h09);
        send_frame(8'h09, 1'b1);
        chk("f09_peak", {28'd0, aging_peak}, 32'd9);
        chk("f09_alarm", {31'd0, aging_alarm}, 32'd1);

        // clr_peak alone
        clr_peak = 1'b1;
        @(negedge clk);
        clr_peak = 1'b0;
        @(negedge clk);
        chk("clr_peak_only", {28'd0, aging_peak}, 32'd0);
        chk("clr_alarm_only", {31'd0, aging_alarm}, 32'd0);
        chk("clr_level_kept", {28'd0, aging_level}, 32'd9);
        chk("clr_cnt_kept", {16'd0, frame_cnt}, 32'd7);

        // reset in the middle of DATA
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        chk("mid_state_data", {29'd0, fsm_state}, 32'd2);
        reset_Q1 = 1'b1;
        #1;
        chk("mid_rst_rx_data", {24'd0, rx_data}, 32'd0);
        chk("mid_rst_level", {28'd0, aging_level}, 32'd0);
        chk("mid_rst_cnt", {16'd0, frame_cnt}, 32'd0);
        chk("mid_rst_state", {29'd0, fsm_state}, 32'd0);
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        reset_Q1 = 1'b0;
        repeat (20) @(negedge clk);
        clear_mon();
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1);
        chk("post_rst_valid", valid_cnt, 1);
        chk("post_rst_level", {28'd0, aging_level}, 32'd7);
        chk("post_rst_peak", {28'd0, aging_peak}, 32'd7);
        chk("post_rst_cnt", {16'd0, frame_cnt}, 32'd1);

`ifdef AGING_RX_PARITY_EN
        // even parity: 0x03 has two ones, so parity bit 0 is correct
        clear_mon();
        exp_q.push_back(8'h03);
        send_frame_p(8'h03, 1'b1, 1'b0);
        chk("par_ok_valid", valid_cnt, 1);
        chk("par_ok_cnt", {16'd0, frame_cnt}, 32'd2);
        clear_mon();
        send_frame_p(8'h03, 1'b1, 1'b1);
        chk("par_bad_err", err_cnt, 1);
        chk("par_bad_valid", valid_cnt, 0);
        chk("par_bad_cnt", {16'd0, frame_cnt}, 32'd2);
`endif

        repeat (4) @(negedge clk);
        chk("never_both", both_cnt, 0);
        chk("sb_drained", exp_q.size(), 0);

        // report
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
